code_lock_ctrl: RTL and testbench

Sequencing controller for the keypad code-entry path. It takes decoded digit, enter and clear pulses and collects a 3-digit BCD code into a display register. It compares the code against a stored code, counts failed tries with timed lockout, and lets a new code be programmed while unlocked. It sits between the keypad decoder and the 7-segment display / lock actuator.

---
 rtl/code_lock_ctrl.sv | 154 +++++++++++++++
 tb/tb_code_lock_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/code_lock_ctrl.sv
// Keypad code-lock sequencer: collects a 3-digit BCD code, compares it against a
// stored code, and handles open/fail/lockout timing and code reprogramming.
module code_lock_ctrl #(
  parameter logic [11:0] DEFAULT_CODE   = 12'h123,
  parameter int unsigned MAX_TRIES      = 6,
  parameter int unsigned UNLOCK_CYCLES  = 50_000_000,
  parameter int unsigned FAIL_CYCLES    = 25_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 500_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        enter,
  input  logic        clear,
  input  logic        set_req,
  output logic [11:0] display,
  output logic [1:0]  digit_cnt,
  output logic        unlocked,
  output logic        error,
  output logic        locked_out,
  output logic        set_active,
  output logic [2:0]  tries
);

  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_FAIL,
    ST_LOCKOUT,
    ST_SETCODE
  } state_t;

  localparam logic [31:0] UNLOCK_LAST  = 32'(UNLOCK_CYCLES - 1);
  localparam logic [31:0] FAIL_LAST    = 32'(FAIL_CYCLES - 1);
  localparam logic [31:0] LOCKOUT_LAST = 32'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]  MAX_T        = 3'(MAX_TRIES);
  localparam logic [11:0] BLANK        = 12'hFFF;

  state_t      state_q, state_d;
  logic [11:0] display_q, display_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [11:0] code_q, code_d;
  logic [2:0]  tries_q, tries_d;
  logic [31:0] timer_q, timer_d;
  logic        digit_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ENTRY;
      display_q <= BLANK;
      cnt_q     <= 2'd0;
      code_q    <= DEFAULT_CODE;
      tries_q   <= 3'd0;
      timer_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      display_q <= display_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      tries_q   <= tries_d;
      timer_q   <= timer_d;
    end
  end

  // A digit only counts when it is a real BCD value and there is room for it.
  assign digit_ok = digit_valid && (digit <= 4'd9) && (cnt_q != 2'd3);

  always_comb begin
    state_d   = state_q;
    display_d = display_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    tries_d   = tries_q;
    timer_d   = timer_q;
    case (state_q)
      ST_ENTRY, ST_SETCODE: begin
        if (clear) begin
          state_d   = ST_ENTRY;
          display_d = BLANK;
          cnt_d     = 2'd0;
        end else if (enter) begin
          if (cnt_q == 2'd3) begin
            if (state_q == ST_ENTRY) begin
              state_d = ST_CHECK;
            end else begin
              code_d    = display_q;
              state_d   = ST_ENTRY;
              display_d = BLANK;
              cnt_d     = 2'd0;
            end
          end
        end else if (digit_ok) begin
          display_d = {display_q[7:0], digit};
          cnt_d     = cnt_q + 2'd1;
        end
      end
      ST_CHECK: begin
        if (display_q == code_q) begin
          state_d = ST_OPEN;
          tries_d = 3'd0;
        end else if (tries_q + 3'd1 == MAX_T) begin
          state_d = ST_LOCKOUT;
          tries_d = MAX_T;
        end else begin
          state_d = ST_FAIL;
          tries_d = tries_q + 3'd1;
        end
      end
      ST_OPEN: begin
        timer_d = timer_q + 32'd1;
        if (set_req) begin
          state_d   = ST_SETCODE;
          display_d = BLANK;
          cnt_d     = 2'd0;
        end else if (timer_q == UNLOCK_LAST) begin
          state_d   = ST_ENTRY;
          display_d = BLANK;
          cnt_d     = 2'd0;
        end
      end
      ST_FAIL: begin
        timer_d = timer_q + 32'd1;
        if (timer_q == FAIL_LAST) begin
          state_d   = ST_ENTRY;
          display_d = BLANK;
          cnt_d     = 2'd0;
        end
      end
      ST_LOCKOUT: begin
        timer_d = timer_q + 32'd1;
        if (timer_q == LOCKOUT_LAST) begin
          state_d   = ST_ENTRY;
          display_d = BLANK;
          cnt_d     = 2'd0;
          tries_d   = 3'd0;
        end
      end
      default: state_d = ST_ENTRY;
    endcase
    // Every timed state starts counting from zero.
    if (state_d != state_q) timer_d = 32'd0;
  end

  assign display    = display_q;
  assign digit_cnt  = cnt_q;
  assign tries      = tries_q;
  assign unlocked   = (state_q == ST_OPEN);
  assign error      = (state_q == ST_FAIL);
  assign locked_out = (state_q == ST_LOCKOUT);
  assign set_active = (state_q == ST_SETCODE);

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Bench for code_lock_ctrl: directed scenarios plus random pulses, compared each
// cycle against a digit-queue / countdown model of the lock behaviour.
module tb_code_lock_ctrl;

  localparam int UNLOCK = 4;
  localparam int FAILC  = 2;
  localparam int LOCKC  = 8;
  localparam int MAXT   = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        digit_valid, enter, clear, set_req;
  logic [3:0]  digit;
  logic [11:0] display;
  logic [1:0]  digit_cnt;
  logic        unlocked, error, locked_out, set_active;
  logic [2:0]  tries;

  code_lock_ctrl #(
    .DEFAULT_CODE   (12'h123),
    .MAX_TRIES      (MAXT),
    .UNLOCK_CYCLES  (UNLOCK),
    .FAIL_CYCLES    (FAILC),
    .LOCKOUT_CYCLES (LOCKC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_valid (digit_valid),
    .digit       (digit),
    .enter       (enter),
    .clear       (clear),
    .set_req     (set_req),
    .display     (display),
    .digit_cnt   (digit_cnt),
    .unlocked    (unlocked),
    .error       (error),
    .locked_out  (locked_out),
    .set_active  (set_active),
    .tries       (tries)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: entered digits as a queue, flags as countdowns
  typedef enum {M_ENTRY, M_CHECK, M_OPEN, M_FAIL, M_LOCK, M_SET} mode_t;
  int    m_digits[$];
  int    m_code[3];
  int    m_tries;
  int    m_left;
  mode_t m_mode;

  task automatic model_reset();
    m_digits.delete();
    m_code[0] = 1; m_code[1] = 2; m_code[2] = 3;
    m_tries = 0;
    m_left  = 0;
    m_mode  = M_ENTRY;
  endtask

  function automatic logic [11:0] m_display();
    logic [11:0] v;
    v = 12'hFFF;
    foreach (m_digits[i]) v = {v[7:0], 4'(m_digits[i])};
    return v;
  endfunction

  task automatic model_edge(input logic clr, input logic ent, input logic dv,
                            input logic [3:0] d, input logic sreq);
    bit hit;
    case (m_mode)
      M_ENTRY, M_SET: begin
        if (clr) begin
          m_digits.delete();
          m_mode = M_ENTRY;
        end else if (ent) begin
          if (m_digits.size() == 3) begin
            if (m_mode == M_ENTRY) m_mode = M_CHECK;
            else begin
              for (int i = 0; i < 3; i++) m_code[i] = m_digits[i];
              m_digits.delete();
              m_mode = M_ENTRY;
            end
          end
        end else if (dv && d <= 4'd9 && m_digits.size() < 3) begin
          m_digits.push_back(int'(d));
        end
      end
      M_CHECK: begin
        hit = 1'b1;
        for (int i = 0; i < 3; i++) if (m_digits[i] != m_code[i]) hit = 1'b0;
        if (hit) begin
          m_mode = M_OPEN; m_left = UNLOCK; m_tries = 0;
        end else if (m_tries + 1 == MAXT) begin
          m_mode = M_LOCK; m_left = LOCKC; m_tries = MAXT;
        end else begin
          m_mode = M_FAIL; m_left = FAILC; m_tries = m_tries + 1;
        end
      end
      M_OPEN: begin
        if (sreq) begin
          m_mode = M_SET;
          m_digits.delete();
        end else begin
          m_left--;
          if (m_left == 0) begin m_mode = M_ENTRY; m_digits.delete(); end
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          if (m_mode == M_LOCK) m_tries = 0;
          m_mode = M_ENTRY;
          m_digits.delete();
        end
      end
    endcase
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".display"},    32'(display),    32'(m_display()));
    check({tag, ".digit_cnt"},  32'(digit_cnt),  32'(m_digits.size()));
    check({tag, ".tries"},      32'(tries),      32'(m_tries));
    check({tag, ".unlocked"},   32'(unlocked),   32'(m_mode == M_OPEN));
    check({tag, ".error"},      32'(error),      32'(m_mode == M_FAIL));
    check({tag, ".locked_out"}, 32'(locked_out), 32'(m_mode == M_LOCK));
    check({tag, ".set_active"}, 32'(set_active), 32'(m_mode == M_SET));
  endtask

  // driver tasks
  task automatic step(input logic clr, input logic ent, input logic dv,
                      input logic [3:0] d, input logic sreq, input string tag);
    clear = clr; enter = ent; digit_valid = dv; digit = d; set_req = sreq;
    @(posedge clk);
    model_edge(clr, ent, dv, d, sreq);
    #1;
    compare_all(tag);
    clear = 1'b0; enter = 1'b0; digit_valid = 1'b0; set_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, "idle");
  endtask

  task automatic press(input logic [3:0] d);
    step(1'b0, 1'b0, 1'b1, d, 1'b0, "digit");
  endtask

  task automatic submit(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    press(a); press(b); press(c);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "enter");
  endtask

  // Reset lands between clock edges; outputs must drop without a clock.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0; enter = 1'b0; digit_valid = 1'b0; digit = 4'd0; set_req = 1'b0;
    model_reset();
    #12;
    compare_all("reset");
    check("reset_display", 32'(display), 32'h0000_0FFF);
    @(negedge clk) rst_n = 1'b1;

    // correct code
    press(4'd1); press(4'd2); press(4'd3);
    check("correct_disp", 32'(display), 32'h123);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "enter");
    idle(1);
    check("correct_unlocked", 32'(unlocked), 32'd1);
    idle(UNLOCK + 1);
    check("correct_blank", 32'(display), 32'hFFF);

    // overflow, clear, lone enter
    press(4'd4); press(4'd5); press(4'd6); press(4'd7);
    check("overflow_disp", 32'(display), 32'h456);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "clear");
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "lone_enter");
    idle(2);

    // lockout after three wrong codes; digits during lockout ignored
    for (int k = 0; k < 3; k++) begin
      submit(4'd9, 4'd9, 4'd9);
      idle(1);
      press(4'd5); press(4'd6);
      idle(LOCKC);
    end
    check("lockout_tries_cleared", 32'(tries), 32'd0);

    // code change to 707
    submit(4'd1, 4'd2, 4'd3);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, "set_req");
    check("set_active", 32'(set_active), 32'd1);
    submit(4'd7, 4'd0, 4'd7);
    submit(4'd1, 4'd2, 4'd3);
    idle(FAILC + 2);
    submit(4'd7, 4'd0, 4'd7);
    idle(1);
    check("new_code_unlocked", 32'(unlocked), 32'd1);
    idle(UNLOCK + 1);

    // priority: clear beats enter and digit
    press(4'd7); press(4'd0); press(4'd7);
    step(1'b1, 1'b1, 1'b1, 4'd5, 1'b0, "priority");
    idle(2);

    // reset in the middle of OPEN restores the default code
    submit(4'd7, 4'd0, 4'd7);
    idle(2);
    async_reset("reset_mid_open");
    submit(4'd1, 4'd2, 4'd3);
    idle(1);
    check("default_restored", 32'(unlocked), 32'd1);
    idle(UNLOCK + 1);

    // random pulses
    for (int i = 0; i < 2500; i++) begin
      logic clr, ent, dv, sr;
      logic [3:0] d;
      clr = ($urandom_range(0, 29) == 0);
      ent = ($urandom_range(0, 4) == 0);
      dv  = ($urandom_range(0, 1) == 0);
      sr  = ($urandom_range(0, 5) == 0);
      d   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
      step(clr, ent, dv, d, sr, "random");
      if ($urandom_range(0, 399) == 0) async_reset("random_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
